vga_frame_reader: RTL



---
 rtl/vga_frame_reader_pkg.sv | 42 ++++
 rtl/vga_frame_reader_timing.sv | 45 ++++
 rtl/vga_frame_reader.sv | 108 ++++++++++
 3 files changed

// File: rtl/vga_frame_reader_pkg.sv
// Shared 640x480@60 VGA timing constants and pixel-source encoding.
// Reused by the capture block and the frame reader.
package vga_frame_reader_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t H_ACT_C    = cnt_t'(H_ACTIVE);
  localparam cnt_t H_LAST     = cnt_t'(H_TOTAL - 1);
  localparam cnt_t H_SYNC_BEG = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t H_SYNC_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam cnt_t V_ACT_C    = cnt_t'(V_ACTIVE);
  localparam cnt_t V_LAST     = cnt_t'(V_TOTAL - 1);
  localparam cnt_t V_SYNC_BEG = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t V_SYNC_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    SRC_BLANK,
    SRC_BG,
    SRC_RAM
  } pix_src_e;

  function automatic logic in_range(input cnt_t x, input cnt_t lo, input cnt_t hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/vga_frame_reader_timing.sv
// 640x480@60 h/v counters with combinational sync, active and frame-end decode
// of the current counter values.
module vga_timing
  import vga_frame_reader_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  output cnt_t h_o,
  output cnt_t v_o,
  output logic hsync_n_o,
  output logic vsync_n_o,
  output logic active_o,
  output logic frame_end_o
);

  cnt_t h_q, h_d;
  cnt_t v_q, v_d;

  always_comb begin
    h_d = h_q + cnt_t'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o         = h_q;
  assign v_o         = v_q;
  assign hsync_n_o   = !in_range(h_q, H_SYNC_BEG, H_SYNC_END);
  assign vsync_n_o   = !in_range(v_q, V_SYNC_BEG, V_SYNC_END);
  assign active_o    = (h_q < H_ACT_C) && (v_q < V_ACT_C);
  assign frame_end_o = (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: rtl/vga_frame_reader.sv
// Frame-buffer read side: VGA timing, incremental row-major read addressing for a
// top-left IMG_W x IMG_H window, and a 2-clk aligned colour/sync output pipeline.
module vga_frame_reader
  import vga_frame_reader_pkg::*;
#(
  parameter int unsigned   AW       = 17,
  parameter int unsigned   DW       = PIX_W,
  parameter int unsigned   IMG_W    = 320,
  parameter int unsigned   IMG_H    = 240,
  parameter logic [DW-1:0] BG_COLOR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] rgb,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start
);

  cnt_t h, v;
  logic hs_n, vs_n, active, frame_end, in_img, first_px;

  vga_timing u_timing (
    .clk_i      (clk),
    .rst_ni     (rst),
    .h_o        (h),
    .v_o        (v),
    .hsync_n_o  (hs_n),
    .vsync_n_o  (vs_n),
    .active_o   (active),
    .frame_end_o(frame_end)
  );

  assign in_img   = (h < cnt_t'(IMG_W)) && (v < cnt_t'(IMG_H));
  assign first_px = (h == '0) && (v == '0);

  // addr_cnt_q is the address of the next in-image pixel; rd_addr_q holds the last one issued.
  logic [AW-1:0] addr_cnt_q, addr_cnt_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;

  always_comb begin
    addr_cnt_d = addr_cnt_q;
    rd_addr_d  = rd_addr_q;
    if (frame_end) begin
      addr_cnt_d = '0;
      rd_addr_d  = '0;
    end else if (in_img) begin
      rd_addr_d  = addr_cnt_q;
      addr_cnt_d = addr_cnt_q + AW'(1);
    end
  end

  logic     hs1_q, vs1_q, act1_q, img1_q, first1_q;
  logic     hsync_q, vsync_q, fs_q;
  pix_src_e src_q, src_d;

  always_comb begin
    src_d = SRC_BLANK;
    if (en && act1_q) src_d = img1_q ? SRC_RAM : SRC_BG;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_cnt_q <= '0;
      rd_addr_q  <= '0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      act1_q     <= 1'b0;
      img1_q     <= 1'b0;
      first1_q   <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      fs_q       <= 1'b0;
      src_q      <= SRC_BLANK;
    end else begin
      addr_cnt_q <= addr_cnt_d;
      rd_addr_q  <= rd_addr_d;
      hs1_q      <= hs_n;
      vs1_q      <= vs_n;
      act1_q     <= active;
      img1_q     <= in_img;
      first1_q   <= first_px;
      hsync_q    <= hs1_q;
      vsync_q    <= vs1_q;
      fs_q       <= first1_q;
      src_q      <= src_d;
    end
  end

  // rd_data is already the RAM's output register; muxing it here keeps rgb on the same clk as the syncs.
  always_comb begin
    rgb = '0;
    unique case (src_q)
      SRC_RAM:   rgb = rd_data;
      SRC_BG:    rgb = BG_COLOR;
      default:   rgb = '0;
    endcase
  end

  assign rd_addr     = rd_addr_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;

endmodule
